// File: rtl/uart_pkg.sv
// Shared UART receive-path definitions: parity encoding, receive FSM states
// and the default oversampling ratio.
package uart_pkg;

  localparam logic [1:0] PAR_NONE00 = 2'b00;
  localparam logic [1:0] PAR_ODD    = 2'b01;
  localparam logic [1:0] PAR_EVEN   = 2'b10;
  localparam logic [1:0] PAR_NONE11 = 2'b11;

  localparam int unsigned DEFAULT_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  function automatic logic has_parity(input logic [1:0] ptype);
    case (ptype)
      PAR_ODD, PAR_EVEN:      return 1'b1;
      PAR_NONE00, PAR_NONE11: return 1'b0;
      default:                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_deframer_if.sv
// Serial-in / captured-frame-out bundle of the UART receive deframer.
// The master side is the deframer; the slave side feeds it and consumes the frame.
interface uart_rx_deframer_if;
  logic       baud_tick;
  logic       rx;
  logic [1:0] parity_type;
  logic [7:0] raw_data;
  logic       start_bit;
  logic       parity_bit;
  logic       stop_bit;
  logic       recieved_flag;
  logic       rx_busy;

  modport master (
    input  baud_tick, rx, parity_type,
    output raw_data, start_bit, parity_bit, stop_bit, recieved_flag, rx_busy
  );

  modport slave (
    output baud_tick, rx, parity_type,
    input  raw_data, start_bit, parity_bit, stop_bit, recieved_flag, rx_busy
  );
endinterface

// File: rtl/sync_ff.sv
// Parameterised-depth flop chain for bringing an asynchronous level into clk.
module sync_ff #(
  parameter int unsigned DEPTH   = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {DEPTH{RST_VAL}};
    end else begin
      sync_q[0] <= d_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[DEPTH-1];

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: synchronises rx, finds the start edge and samples
// start/data/parity/stop at mid-bit on the oversampling tick.
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE  = DEFAULT_OVERSAMPLE,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  uart_rx_deframer_if.master  bus
);

  localparam int unsigned    TW   = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0]  MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0]  LAST = TW'(OVERSAMPLE - 1);

  logic            rx_s;
  rx_state_t       state_q;
  logic [TW-1:0]   tick_q;
  logic [2:0]      bit_q;
  logic [1:0]      ptype_q;
  logic [7:0]      data_q;
  logic            start_q;
  logic            par_q;
  logic            stop_q;
  logic            flag_q;
  logic            busy_q;

  sync_ff #(
    .DEPTH   (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (bus.rx),
    .q_o   (rx_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RX_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      ptype_q <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
      par_q   <= 1'b0;
      stop_q  <= 1'b0;
      flag_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      flag_q <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          ptype_q <= bus.parity_type;
          if (!rx_s) begin
            state_q <= RX_START;
            tick_q  <= '0;
            busy_q  <= 1'b1;
          end
        end
        RX_START: if (bus.baud_tick) begin
          // A high start sample is reported, not aborted.
          if (tick_q == MID) begin
            start_q <= rx_s;
            tick_q  <= '0;
            bit_q   <= '0;
            state_q <= RX_DATA;
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        RX_DATA: if (bus.baud_tick) begin
          if (tick_q == LAST) begin
            data_q[bit_q] <= rx_s;
            tick_q        <= '0;
            if (bit_q == 3'd7) begin
              if (has_parity(ptype_q)) begin
                state_q <= RX_PARITY;
              end else begin
                state_q <= RX_STOP;
                par_q   <= 1'b1;
              end
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        RX_PARITY: if (bus.baud_tick) begin
          if (tick_q == LAST) begin
            par_q   <= rx_s;
            tick_q  <= '0;
            state_q <= RX_STOP;
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        RX_STOP: if (bus.baud_tick) begin
          // Leave at mid stop bit so an immediately following start edge is seen.
          if (tick_q == LAST) begin
            stop_q  <= rx_s;
            tick_q  <= '0;
            flag_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= RX_IDLE;
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        default: begin
          state_q <= RX_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.raw_data      = data_q;
  assign bus.start_bit     = start_q;
  assign bus.parity_bit    = par_q;
  assign bus.stop_bit      = stop_q;
  assign bus.recieved_flag = flag_q;
  assign bus.rx_busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Randomised bench for uart_rx_deframer: frames are serialised at 16x ticks and
// each flag is checked against fields and tick latency predicted from the frame.
module tb_uart_rx_deframer;

  localparam int unsigned OS = 16;

  typedef struct {
    logic [7:0]  data;
    logic        start;
    logic        par;
    logic        stop;
    int unsigned ticks;
  } exp_t;

  logic clk;
  logic reset;
  uart_rx_deframer_if bus ();

  uart_rx_deframer #(
    .OVERSAMPLE  (OS),
    .SYNC_STAGES (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t        expq[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned n_flags  = 0;
  int unsigned n_pushed = 0;
  int unsigned tcnt     = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One baud_tick pulse every 4 clk
  initial begin
    bus.baud_tick = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 bus.baud_tick = 1'b1;
      @(posedge clk);
      #1 bus.baud_tick = 1'b0;
    end
  end

  // Flag monitor: counts ticks processed outside IDLE and checks the popped frame.
  always @(negedge clk) begin
    if (reset) begin
      tcnt = 0;
    end else begin
      if (bus.baud_tick && bus.rx_busy) tcnt++;
      if (bus.recieved_flag) begin
        exp_t e;
        n_flags++;
        chk("flag_expected", 32'(expq.size() != 0), 32'd1);
        if (expq.size() != 0) begin
          e = expq.pop_front();
          chk("raw_data",     32'(bus.raw_data),   32'(e.data));
          chk("start_bit",    32'(bus.start_bit),  32'(e.start));
          chk("parity_bit",   32'(bus.parity_bit), 32'(e.par));
          chk("stop_bit",     32'(bus.stop_bit),   32'(e.stop));
          chk("tick_latency", tcnt,                e.ticks);
        end
        tcnt = 0;
      end
    end
  end

  task automatic wait_tick();
    do @(posedge clk); while (bus.baud_tick !== 1'b1);
    #2;
  endtask

  task automatic hold_bit(input logic v);
    bus.rx = v;
    repeat (OS) wait_tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [1:0] pt, input logic pb,
                            input logic sb, input bit glitch, input bit scramble);
    exp_t        e;
    logic        haspar;
    int unsigned t;
    int unsigned edges;
    haspar  = (pt == 2'b01) || (pt == 2'b10);
    e.data  = glitch ? 8'hFF : d;
    e.start = glitch;
    e.par   = haspar ? pb : 1'b1;
    e.stop  = sb;
    e.ticks = OS / 2 + (haspar ? 10 : 9) * OS;
    expq.push_back(e);
    n_pushed++;
    bus.parity_type = pt;
    bus.rx = 1'b0;
    t = 0;
    edges = 0;
    while (t < OS) begin
      @(posedge clk);
      if (bus.baud_tick) t++;
      edges++;
      if (edges == 2) begin
        @(negedge clk);
        chk("busy_before_detect", 32'(bus.rx_busy), 32'd0);
      end else if (edges == 3) begin
        @(negedge clk);
        chk("busy_at_detect", 32'(bus.rx_busy), 32'd1);
      end
      if (glitch && t == 3 && bus.rx == 1'b0) begin
        #2 bus.rx = 1'b1;
      end
    end
    #2;
    for (int i = 0; i < 8; i++) begin
      if (scramble && i == 3) bus.parity_type = 2'($urandom);
      hold_bit(glitch ? 1'b1 : d[i]);
    end
    if (haspar) hold_bit(pb);
    hold_bit(sb);
    bus.rx = 1'b1;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    chk("rst_raw_data",   32'(bus.raw_data),      32'd0);
    chk("rst_start_bit",  32'(bus.start_bit),     32'd0);
    chk("rst_parity_bit", 32'(bus.parity_bit),    32'd0);
    chk("rst_stop_bit",   32'(bus.stop_bit),      32'd0);
    chk("rst_flag",       32'(bus.recieved_flag), 32'd0);
    chk("rst_busy",       32'(bus.rx_busy),       32'd0);
    bus.rx = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
  endtask

  initial begin
    logic [7:0]  d;
    logic [1:0]  pt;
    logic        pb;
    int unsigned flags_before;

    reset = 1'b1;
    bus.rx = 1'b1;
    bus.parity_type = 2'b00;
    repeat (4) @(posedge clk);
    apply_reset();
    repeat (20) wait_tick();
    chk("idle_ticks_busy", 32'(bus.rx_busy), 32'd0);

    // Odd parity, good frame
    send_frame(8'h5A, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (4) wait_tick();
    // No parity, both encodings
    send_frame(8'hC3, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (4) wait_tick();
    send_frame(8'hC3, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (4) wait_tick();

    // Framing error; the line is still low at mid stop, so reset clears the re-trigger
    send_frame(8'hFF, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    flags_before = n_flags;
    apply_reset();
    repeat (OS * 12) wait_tick();
    chk("no_flag_after_ferr_reset", n_flags, flags_before);

    // Start glitch: low for 3 ticks only
    send_frame(8'hFF, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (4) wait_tick();

    // Random frames with parity_type disturbed mid-frame
    for (int k = 0; k < 12; k++) begin
      d  = 8'($urandom);
      pt = 2'($urandom);
      pb = (pt == 2'b01) ? ~(^d) : (^d);
      if ($urandom_range(0, 3) == 0) pb = ~pb;
      send_frame(d, pt, pb, 1'b1, 1'b0, 1'b1);
      repeat ($urandom_range(0, 3)) wait_tick();
    end

    // Reset during data bit 4
    flags_before = n_flags;
    bus.parity_type = 2'b01;
    hold_bit(1'b0);
    for (int i = 0; i < 4; i++) hold_bit(1'b1);
    bus.rx = 1'b0;
    repeat (OS / 2) wait_tick();
    chk("busy_mid_frame", 32'(bus.rx_busy), 32'd1);
    apply_reset();
    repeat (OS * 12) wait_tick();
    chk("no_flag_after_reset", n_flags, flags_before);
    chk("idle_after_reset", 32'(bus.rx_busy), 32'd0);

    // Back-to-back frames
    send_frame(8'h01, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(8'h80, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0);

    for (int c = 0; c < 2000 && expq.size() != 0; c++) @(posedge clk);
    chk("queue_drained", 32'(expq.size()), 32'd0);
    chk("flag_count", n_flags, n_pushed);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
